// File: rtl/vec_dot_pe.sv
`default_nettype none
// ============================================================================
//  Module   : vec_dot_pe
//  Purpose  : Signed fixed-point dot-product engine. It captures two
//             N-element vectors and sums LANES full-precision products per
//             cycle into a wide accumulator. It then rescales the sum by FRAC
//             bits and returns a W-bit result. The result either saturates or
//             wraps, and an overflow flag reports when it left the W-bit range.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1     rising-edge clock
//    rst        in   1     asynchronous active-high reset
//    in_valid   in   1     operands and mode bits valid
//    in_ready   out  1     operands accepted (IDLE only)
//    vec_a      in   N*W   signed elements, element k = [k*W +: W]
//    vec_b      in   N*W   same layout as vec_a
//    acc_mode   in   1     1 = chain onto previous accumulator value
//    sat_en     in   1     1 = saturate result, 0 = wrap
//    out_valid  out  1     dot_out / overflow valid
//    out_ready  in   1     consumer takes the result
//    dot_out    out  W     signed fixed-point result
//    overflow   out  1     result exceeded the W-bit signed range
//  N must be a multiple of LANES.
// ============================================================================
module vec_dot_pe #(
   parameter int N     = 16,
   parameter int W     = 16,
   parameter int FRAC  = 11,
   parameter int LANES = 4,
   parameter int ACC_W = 2*W + $clog2(N) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N*W-1:0]   vec_a,
   input  logic [N*W-1:0]   vec_b,
   input  logic             acc_mode,
   input  logic             sat_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     dot_out,
   output logic             overflow
);

   localparam int BEATS  = N / LANES;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [N*W-1:0]            a_q, a_d;
   logic [N*W-1:0]            b_q, b_d;
   logic                      sat_q, sat_d;
   logic [BEAT_W-1:0]         beat_q, beat_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [W-1:0]              dot_q, dot_d;
   logic                      ovf_q, ovf_d;
   logic                      out_valid_q, out_valid_d;

   logic signed [W-1:0]       elem_a, elem_b;
   logic signed [2*W-1:0]     prod;
   logic signed [ACC_W-1:0]   beat_sum;
   logic signed [ACC_W-1:0]   shifted;
   logic [ACC_W-W:0]          shifted_hi;
   logic                      in_range;
   logic [W-1:0]              sat_val;
   int                        idx;

   // Gated with rst so in_ready is low for the whole reset pulse.
   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign dot_out   = dot_q;
   assign overflow  = ovf_q;

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sat_d       = sat_q;
      beat_d      = beat_q;
      acc_d       = acc_q;
      dot_d       = dot_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      elem_a      = '0;
      elem_b      = '0;
      prod        = '0;
      beat_sum    = '0;
      idx         = 0;

      // Sum of this beat's LANES products, each sign-extended at full precision.
      for (int l = 0; l < LANES; l++) begin
         idx      = int'(beat_q) * LANES + l;
         elem_a   = a_q[idx*W +: W];
         elem_b   = b_q[idx*W +: W];
         prod     = elem_a * elem_b;
         beat_sum = beat_sum + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
      end

      // Arithmetic shift floors toward -inf. The value is in range when all
      // bits from W-1 upward agree with the sign.
      shifted    = acc_q >>> FRAC;
      shifted_hi = shifted[ACC_W-1:W-1];
      in_range   = (&shifted_hi) || !(|shifted_hi);
      sat_val    = shifted[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               a_d     = vec_a;
               b_d     = vec_b;
               sat_d   = sat_en;
               beat_d  = '0;
               acc_d   = acc_mode ? acc_q : '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d  = acc_q + beat_sum;
            beat_d = beat_q + BEAT_W'(1);
            if (beat_q == BEAT_W'(BEATS-1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // The first DONE cycle registers the rescaled result. Later cycles
            // hold it until the consumer takes it.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               ovf_d       = !in_range;
               dot_d       = in_range ? shifted[W-1:0] :
                             (sat_q ? sat_val : shifted[W-1:0]);
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sat_q       <= 1'b0;
         beat_q      <= '0;
         acc_q       <= '0;
         dot_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sat_q       <= sat_d;
         beat_q      <= beat_d;
         acc_q       <= acc_d;
         dot_q       <= dot_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vec_dot_pe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vec_dot_pe
//  Purpose  : Directed self-checking bench for vec_dot_pe at default sizes
//             (N=16, W=16, FRAC=11, LANES=4; 1.0 = 0x0800).
//  Revision : 1.0  initial release
// ============================================================================
module tb_vec_dot_pe;

   localparam int N = 16;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [N*W-1:0] vec_a = '0;
   logic [N*W-1:0] vec_b = '0;
   logic           acc_mode = 1'b0;
   logic           sat_en = 1'b0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [W-1:0]   dot_out;
   logic           overflow;

   int total = 0;
   int bad   = 0;

   logic [N*W-1:0] va;
   logic [N*W-1:0] vb;

   vec_dot_pe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .vec_a     (vec_a),
      .vec_b     (vec_b),
      .acc_mode  (acc_mode),
      .sat_en    (sat_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dot_out   (dot_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
      return {N{v}};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present operands, accept on the next edge, then scramble the inputs so
   // that a design which fails to hold its captured copy gives a wrong sum.
   task automatic start_op(input string tag, input logic [N*W-1:0] a,
                           input logic [N*W-1:0] b, input logic am, input logic se);
      chk({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
      vec_a    = a;
      vec_b    = b;
      acc_mode = am;
      sat_en   = se;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      vec_a    = ~a;
      vec_b    = ~b;
      acc_mode = ~am;
      sat_en   = ~se;
      chk({tag, "/in_ready_busy"}, 32'(in_ready), 32'd0);
   endtask

   // out_valid must be low for edges 1..4 after accept and high at edge 5.
   task automatic wait_result(input string tag, input logic [W-1:0] exp_dot, input logic exp_ovf);
      for (int e = 1; e <= 5; e++) begin
         @(posedge clk); #1;
         chk($sformatf("%s/out_valid_e%0d", tag, e), 32'(out_valid), (e == 5) ? 32'd1 : 32'd0);
      end
      chk({tag, "/dot_out"}, 32'(dot_out), 32'(exp_dot));
      chk({tag, "/overflow"}, 32'(overflow), 32'(exp_ovf));
   endtask

   task automatic take_result(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "/out_valid_after_take"}, 32'(out_valid), 32'd0);
      chk({tag, "/in_ready_after_take"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst/in_ready", 32'(in_ready), 32'd0);
      chk("rst/out_valid", 32'(out_valid), 32'd0);
      chk("rst/dot_out", 32'(dot_out), 32'd0);
      chk("rst/overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_release/in_ready", 32'(in_ready), 32'd1);

      // 16 * (1.0 * 0.5) = 8.0
      start_op("half", fill(16'h0800), fill(16'h0400), 1'b0, 1'b0);
      wait_result("half", 16'h4000, 1'b0);
      take_result("half");

      // 16 * 1.0 = 16.0 exceeds range: saturate, then wrap
      start_op("sat_pos", fill(16'h0800), fill(16'h0800), 1'b0, 1'b1);
      wait_result("sat_pos", 16'h7FFF, 1'b1);
      take_result("sat_pos");
      start_op("wrap_pos", fill(16'h0800), fill(16'h0800), 1'b0, 1'b0);
      wait_result("wrap_pos", 16'h8000, 1'b1);
      take_result("wrap_pos");

      // -1.0 * 1 LSB = -2048 raw -> floor(-2048/2048) = -1.
      // out_ready is held high through IDLE and RUN, where it must do nothing.
      va = '0; va[W-1:0] = 16'hF800;
      vb = '0; vb[W-1:0] = 16'h0001;
      out_ready = 1'b1;
      start_op("floor", va, vb, 1'b0, 1'b1);
      wait_result("floor", 16'hFFFF, 1'b0);
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("floor/out_valid_after_take", 32'(out_valid), 32'd0);

      // Chaining: 4.0 then 4.0 + 4.0
      start_op("chain1", fill(16'h0800), fill(16'h0200), 1'b0, 1'b0);
      wait_result("chain1", 16'h2000, 1'b0);
      take_result("chain1");
      start_op("chain2", fill(16'h0800), fill(16'h0200), 1'b1, 1'b0);
      wait_result("chain2", 16'h4000, 1'b0);
      take_result("chain2");

      // 16 * (-1.0 * 2.0) = -32.0 -> -65536 raw: negative clamp, then wrap to 0
      start_op("sat_neg", fill(16'hF800), fill(16'h1000), 1'b0, 1'b1);
      wait_result("sat_neg", 16'h8000, 1'b1);
      take_result("sat_neg");
      start_op("wrap_neg", fill(16'hF800), fill(16'h1000), 1'b0, 1'b0);
      wait_result("wrap_neg", 16'h0000, 1'b1);
      take_result("wrap_neg");

      // Exactly -16.0 = most negative representable value, no overflow
      start_op("min_edge", fill(16'hF800), fill(16'h0800), 1'b0, 1'b1);
      wait_result("min_edge", 16'h8000, 1'b0);
      take_result("min_edge");

      // 0x7FFF * 1.0 = most positive representable value, no overflow
      va = '0; va[W-1:0] = 16'h7FFF;
      vb = '0; vb[W-1:0] = 16'h0800;
      start_op("max_edge", va, vb, 1'b0, 1'b1);
      wait_result("max_edge", 16'h7FFF, 1'b0);
      take_result("max_edge");

      // Position weighting: a = 1.0, b[k] = k LSB -> sum k = 120 = 0x78
      va = fill(16'h0800);
      for (int k = 0; k < N; k++) vb[k*W +: W] = 16'(k);
      start_op("index", va, vb, 1'b0, 1'b0);
      wait_result("index", 16'h0078, 1'b0);
      take_result("index");

      // Back-pressure: 10 cycles of out_ready=0 with in_valid pulses
      start_op("stall", fill(16'h0800), fill(16'h0400), 1'b0, 1'b0);
      wait_result("stall", 16'h4000, 1'b0);
      vec_a    = fill(16'h1234);
      vec_b    = fill(16'h4321);
      acc_mode = 1'b0;
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0];
         @(posedge clk); #1;
         chk($sformatf("stall/out_valid_c%0d", c), 32'(out_valid), 32'd1);
         chk($sformatf("stall/dot_out_c%0d", c), 32'(dot_out), 32'h4000);
         chk($sformatf("stall/overflow_c%0d", c), 32'(overflow), 32'd0);
         chk($sformatf("stall/in_ready_c%0d", c), 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      take_result("stall");
      @(posedge clk); #1;
      chk("stall/no_spurious_op", 32'(out_valid), 32'd0);

      // Reset in the second RUN cycle, leaving a negative partial sum behind
      start_op("abort", fill(16'hF800), fill(16'h1000), 1'b0, 1'b0);
      @(posedge clk); #1;
      #2;
      rst = 1'b1;
      #1;
      chk("abort/out_valid", 32'(out_valid), 32'd0);
      chk("abort/dot_out", 32'(dot_out), 32'd0);
      chk("abort/overflow", 32'(overflow), 32'd0);
      chk("abort/in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort/in_ready_release", 32'(in_ready), 32'd1);
      start_op("after_abort", fill(16'h0800), fill(16'h0800), 1'b1, 1'b1);
      wait_result("after_abort", 16'h7FFF, 1'b1);
      take_result("after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case the sequence above stalls.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
